// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending scoreboard, same-cycle write
// bypass and a hardware clear sequencer that zeroes the array after reset.

module regfile_mp_rd #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                ready,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     reg_data,
    input  logic                reg_pend,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]     rd_data,
    output logic                rd_pending
);
    always_comb begin
        rd_data    = '0;
        rd_pending = 1'b0;
        if (ready && !((ZERO_REG != 0) && (rd_addr == '0))) begin
            rd_data    = reg_data;
            rd_pending = reg_pend;
            // ascending scan: the highest matching lane overrides lower ones
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && (wr_addr[i*AW +: AW] == rd_addr)) begin
                    rd_data    = wr_data[i*XLEN +: XLEN];
                    rd_pending = 1'b0;
                end
            end
        end
    end
endmodule

module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_req,
    output logic                init_done,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pending
);
    typedef enum logic {CLEAR, READY} state_t;

    state_t             state;
    logic [AW-1:0]      cnt;
    logic [XLEN-1:0]    mem [NREGS];
    logic [NREGS-1:0]   pend, pend_nxt;
    logic [NWR-1:0]     wr_ok;
    logic               alloc_ok;
    logic               ready;

    assign ready    = (state == READY);
    assign alloc_ok = ready && alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

    always_comb begin
        for (int i = 0; i < NWR; i++)
            wr_ok[i] = ready && wr_en[i] &&
                       !((ZERO_REG != 0) && (wr_addr[i*AW +: AW] == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_done <= 1'b0;
        end else if (clear_req) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_done <= 1'b0;
        end else if (state == CLEAR) begin
            if (cnt == AW'(NREGS-1)) begin
                state     <= READY;
                cnt       <= '0;
                init_done <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Array is not reset; the sequencer zeroes one entry per cycle in CLEAR.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++)
                if (wr_ok[i])
                    mem[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
        end
    end

    // Writes retire producers first, then alloc re-arms (alloc wins on a tie).
    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < NWR; i++)
            if (wr_ok[i]) pend_nxt[wr_addr[i*AW +: AW]] = 1'b0;
        if (alloc_ok) pend_nxt[alloc_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           pend <= '0;
        else if (state == CLEAR || clear_req) pend <= '0;
        else                                  pend <= pend_nxt;
    end

    genvar g;
    generate
        for (g = 0; g < NRD; g++) begin : g_rd
            logic [AW-1:0] ra;
            assign ra = rd_addr[g*AW +: AW];
            regfile_mp_rd #(
                .XLEN(XLEN), .AW(AW), .NWR(NWR), .ZERO_REG(ZERO_REG)
            ) u_rd (
                .ready     (ready),
                .rd_addr   (ra),
                .reg_data  (mem[ra]),
                .reg_pend  (pend[ra]),
                .wr_en     (wr_en),
                .wr_addr   (wr_addr),
                .wr_data   (wr_data),
                .rd_data   (rd_data[g*XLEN +: XLEN]),
                .rd_pending(rd_pending[g])
            );
        end
    endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a ZERO_REG=1 and a ZERO_REG=0 instance share stimulus;
// vector table plus hand sequences for the clear/restart windows.

module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk, rst_n, clear_req;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [63:0]     wr_data;
    logic            alloc_en;
    logic [AW-1:0]   alloc_addr;
    logic [2*AW-1:0] rd_addr;
    logic [63:0]     rd_data, rd_data_z;
    logic [1:0]      rd_pending, rd_pending_z;
    logic            init_done, init_done_z;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_done(init_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending));

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_done(init_done_z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_pending(rd_pending_z));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0; logic [31:0] wd0;
        logic [4:0]  wa1; logic [31:0] wd1;
        logic        al;  logic [4:0]  aa;
        logic [4:0]  ra0; logic [4:0]  ra1;
        logic [31:0] ed0; logic        ep0;
        logic [31:0] ed1; logic        ep1;
        logic [31:0] ezd0;
    } vec_t;

    typedef struct {
        logic [31:0] ed0; logic ep0;
        logic [31:0] ed1; logic ep1;
        logic [31:0] ezd0;
    } exp_t;

    vec_t vq[$];
    exp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic add(input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic al, input logic [4:0] aa,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [31:0] ed0, input logic ep0,
                       input logic [31:0] ed1, input logic ep1, input logic [31:0] ezd0);
        vec_t v;
        v = '{wen, wa0, wd0, wa1, wd1, al, aa, ra0, ra1, ed0, ep0, ed1, ep1, ezd0};
        vq.push_back(v);
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; clear_req = 1'b0;
    endtask

    // Drive at negedge, push expectation, sample 1ns later; inputs hold through posedge.
    task automatic run_table(input string tag);
        exp_t e;
        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            wr_en      = vq[k].wen;
            wr_addr    = {vq[k].wa1, vq[k].wa0};
            wr_data    = {vq[k].wd1, vq[k].wd0};
            alloc_en   = vq[k].al;
            alloc_addr = vq[k].aa;
            rd_addr    = {vq[k].ra1, vq[k].ra0};
            sbq.push_back('{vq[k].ed0, vq[k].ep0, vq[k].ed1, vq[k].ep1, vq[k].ezd0});
            #1;
            e = sbq.pop_front();
            chk($sformatf("%s%0d.d0", tag, k), rd_data[31:0], e.ed0);
            chk($sformatf("%s%0d.p0", tag, k), {31'd0, rd_pending[0]}, {31'd0, e.ep0});
            chk($sformatf("%s%0d.d1", tag, k), rd_data[63:32], e.ed1);
            chk($sformatf("%s%0d.p1", tag, k), {31'd0, rd_pending[1]}, {31'd0, e.ep1});
            chk($sformatf("%s%0d.zd0", tag, k), rd_data_z[31:0], e.ezd0);
        end
        @(negedge clk);
        idle();
        vq.delete();
    endtask

    task automatic wait_init(input string nm);
        int cyc;
        cyc = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            cyc = c;
            if (init_done) break;
        end
        chk(nm, cyc, 32);
        chk({nm, "_z"}, {31'd0, init_done_z}, 32'd1);
    endtask

    initial begin
        idle();
        rd_addr = {5'd6, 5'd5};
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_rd_data0", rd_data[31:0], 32'd0);
        rst_n = 1'b1;
        wait_init("init_cycles");
        @(negedge clk);

        //   wen   wa0    wd0           wa1    wd1     al    aa     ra0    ra1    ed0           ep0   ed1           ep1   ezd0
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0,  5'd5,  5'd6,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
        add(2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0,  5'd3,  5'd3,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0,  5'd3,  5'd5,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF);
        add(2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 1'b0, 5'd0,  5'd7,  5'd7,  32'h22,       1'b0, 32'h22,       1'b0, 32'h22);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0,  5'd7,  5'd3,  32'h22,       1'b0, 32'hDEADBEEF, 1'b0, 32'h22);
        add(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,  1'b0, 5'd0,  5'd0,  5'd7,  32'h0,        1'b0, 32'h22,       1'b0, 32'hFFFFFFFF);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0,  5'd0,  5'd7,  32'h0,        1'b0, 32'h22,       1'b0, 32'hFFFFFFFF);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd9,  5'd9,  5'd9,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0,  5'd9,  5'd9,  32'h0,        1'b1, 32'h0,        1'b1, 32'h0);
        add(2'b10, 5'd0, 32'h0,        5'd9, 32'h5,  1'b0, 5'd0,  5'd9,  5'd9,  32'h5,        1'b0, 32'h5,        1'b0, 32'h5);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0,  5'd9,  5'd9,  32'h5,        1'b0, 32'h5,        1'b0, 32'h5);
        add(2'b01, 5'd9, 32'h6,        5'd0, 32'h0,  1'b1, 5'd9,  5'd9,  5'd9,  32'h6,        1'b0, 32'h6,        1'b0, 32'h6);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0,  5'd9,  5'd9,  32'h6,        1'b1, 32'h6,        1'b1, 32'h6);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd0,  5'd0,  5'd9,  32'h0,        1'b0, 32'h6,        1'b1, 32'hFFFFFFFF);
        add(2'b10, 5'd0, 32'h0,        5'd4, 32'hA5, 1'b1, 5'd11, 5'd4,  5'd9,  32'hA5,       1'b0, 32'h6,        1'b1, 32'hA5);
        add(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0,  5'd4,  5'd11, 32'hA5,       1'b0, 32'h0,        1'b1, 32'hA5);
        run_table("v");

        // Clear request, writes/allocs held during the window, then a restart mid-clear.
        @(negedge clk);
        clear_req = 1'b1;
        rd_addr   = {5'd11, 5'd4};
        @(negedge clk);
        clear_req = 1'b0;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h77};
        alloc_en = 1'b1; alloc_addr = 5'd12;
        #1;
        chk("clr_init_done", {31'd0, init_done}, 32'd0);
        chk("clr_rd_data0", rd_data[31:0], 32'd0);
        chk("clr_rd_pending1", {31'd0, rd_pending[1]}, 32'd0);
        repeat (4) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        wait_init("restart_cycles");
        idle();

        //   wen   wa0   wd0    wa1   wd1    al    aa    ra0   ra1    ed0    ep0   ed1    ep1   ezd0
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd11, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd12, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        add(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7,  32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        run_table("post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the decode-stage register file.
- Configurable width, depth, read-port count and write-port count.
- Per-register pending scoreboard for in-flight producers; same-cycle write-to-read bypass.
- Hardware clear sequencer that zeroes the array after reset or on request.
- Sits in decode: read ports feed operand muxes; write ports are driven by writeback lanes.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; must be a power of 2 and at least 2.
- NRD, 2, number of read ports.
- NWR, 1, number of write ports; lane NWR-1 has highest priority.
- ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes, allocs and pending.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear_req  input  1  single-cycle pulse; restarts the clear sequence.
- init_done  output  1  high when the array is cleared and the file is usable.
- wr_en  input  NWR  per-lane write enable.
- wr_addr  input  NWR*AW  per-lane write address; lane i occupies bits [i*AW +: AW].
- wr_data  input  NWR*XLEN  per-lane write data.
- alloc_en  input  1  marks alloc_addr pending (new in-flight producer).
- alloc_addr  input  AW  register to mark pending.
- rd_addr  input  NRD*AW  per-port read address.
- rd_data  output  NRD*XLEN  per-port read data; combinational.
- rd_pending  output  NRD  per-port flag: the read value is not yet produced.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM enters CLEAR; clear counter cnt = 0; init_done = 0.
  - All pending bits are cleared.
  - Array contents are not reset directly; they are zeroed by the sequencer.
- FSM, two states:
  - CLEAR: each cycle writes 0 to reg[cnt] and increments cnt. When cnt == NREGS-1 is written, the next state is READY and init_done = 1. Total NREGS cycles from reset release.
  - READY: normal operation. clear_req = 1 selects CLEAR next cycle with cnt = 0, init_done = 0 and all pending bits cleared.
  - clear_req during CLEAR restarts cnt at 0.
- While in CLEAR:
  - wr_en and alloc_en are ignored.
  - rd_data = 0 and rd_pending = 0 on all ports.
- Write (READY):
  - At a rising edge, for each lane with wr_en high, reg[wr_addr] <= wr_data.
  - Writes to register 0 are dropped when ZERO_REG = 1.
  - Lanes writing the same address: the highest lane index wins.
  - Each accepted write clears the pending bit of its address.
- Alloc (READY):
  - alloc_en sets pending[alloc_addr] at the rising edge.
  - Alloc and a write to the same address in the same cycle: the pending bit ends set (alloc wins).
- Read (combinational):
  - ZERO_REG = 1 and address 0: rd_data = 0, rd_pending = 0.
  - Otherwise, if any write lane has wr_en high with wr_addr == rd_addr, rd_data = wr_data of the highest such lane and rd_pending = 0 (bypass).
  - Otherwise rd_data = reg[rd_addr] and rd_pending = pending[rd_addr].
  - A same-cycle alloc does not affect rd_pending until the next cycle.
- Latency:
  - A write is visible on the same cycle through the bypass and from the array from the next cycle.
  - An alloc is visible on rd_pending from the next cycle.
- Reset mid-operation: asynchronous return to CLEAR. In-flight writes on the edge coincident with the reset assertion are lost.

Test Plan:
- Release rst_n and hold the inputs idle -> init_done stays 0 for exactly 32 cycles and then rises; reads of x5 return 0x00000000.
- READY, write x3 = 0xDEADBEEF while reading x3 on port 0 in the same cycle -> rd_data0 = 0xDEADBEEF (bypass). Next cycle with no write -> still 0xDEADBEEF from the array.
- NWR = 2: both lanes write x7, lane0 = 0x11, lane1 = 0x22 -> the same-cycle read and every later read return 0x22.
- Write x0 = 0xFFFFFFFF with ZERO_REG = 1 -> read of x0 returns 0 and rd_pending = 0; with ZERO_REG = 0 it returns 0xFFFFFFFF.
- Scoreboard sequence:
  - alloc x9 -> next cycle rd_pending = 1 for x9.
  - Write x9 = 0x5 -> same cycle rd_pending = 0 and data 0x5.
  - Alloc plus write of x9 in one cycle -> next cycle rd_pending = 1.
- After writing x4 = 0xA5, pulse clear_req -> init_done = 0 for 32 cycles; any wr_en during that window is ignored; afterwards reads of x4 return 0 and all pending flags are 0.
